// File: rtl/bubble_host_reader.sv
// Bubble memory host-side page reader.
// Sequences the nBSS/nBSEN strobes for one page access and samples the
// emulator DOUT lines once per bit period. The samples are packed into bytes,
// either one bit per sample or one nibble per sample. Each finished byte is
// handed to the consumer through a DATA/DVALID/DREADY handshake with a sticky
// overrun flag.
//
//  state  | meaning
//  -------+---------------------------------------------------------
//  IDLE   | waiting for START; strobes high, BUSY low
//  LEADIN | nBSS low only, BSS_CYCLES long
//  DELAY  | nBSS low, waiting ACCESS_DELAY cycles for the access
//  READ   | nBSS and nBSEN low, sampling DOUT once per bit period
//  TAIL   | one cycle with all strobes released
//  FIN    | one cycle with the DONE pulse, then back to IDLE
module bubble_host_reader #(
    parameter int BIT_CYCLES    = 12,
    parameter int SAMPLE_OFFSET = 6,
    parameter int BSS_CYCLES    = 48,
    parameter int ACCESS_DELAY  = 96,
    parameter int PAGE_BITS     = 512
) (
    input  logic       MCLK,
    input  logic       MRST,
    input  logic       START,
    input  logic       BOOTMODE,
    input  logic       BITWIDTH4,
    input  logic [3:0] DOUT,
    output logic       nBSS,
    output logic       nBSEN,
    output logic       nREPEN,
    output logic       nBOOTEN,
    output logic       nSWAPEN,
    output logic [7:0] DATA,
    output logic       DVALID,
    input  logic       DREADY,
    output logic       BUSY,
    output logic       DONE,
    output logic       OVERRUN
);

    localparam int READ_CYCLES = PAGE_BITS * BIT_CYCLES;
    localparam int MAX_AB      = (BSS_CYCLES > ACCESS_DELAY) ? BSS_CYCLES : ACCESS_DELAY;
    localparam int MAX_LEN     = (READ_CYCLES > MAX_AB) ? READ_CYCLES : MAX_AB;
    localparam int TMR_W       = $clog2(MAX_LEN + 1);
    localparam int PH_W        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEADIN,
        S_DELAY,
        S_READ,
        S_TAIL,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [2:0]       smp_cnt_q, smp_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             boot_q, boot_d;
    logic             bw4_q, bw4_d;
    logic [7:0]       data_q, data_d;
    logic             dvalid_q, dvalid_d;
    logic             overrun_q, overrun_d;
    logic             nbss_q, nbss_d;
    logic             nbsen_q, nbsen_d;
    logic             nbooten_q, nbooten_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sample;
    logic             byte_done;
    logic [7:0]       new_byte;
    logic             tmr_tc;
    logic             phase_wrap;

    // Next-state, timer, byte assembly and handshake logic.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        phase_d    = phase_q;
        smp_cnt_d  = smp_cnt_q;
        shift_d    = shift_q;
        boot_d     = boot_q;
        bw4_d      = bw4_q;
        data_d     = data_q;
        dvalid_d   = dvalid_q;
        overrun_d  = overrun_q;
        byte_done  = 1'b0;
        new_byte   = shift_q;

        tmr_tc     = (tmr_q == '0);
        phase_wrap = (phase_q == PH_W'(BIT_CYCLES - 1));
        sample     = (state_q == S_READ) && (phase_q == PH_W'(SAMPLE_OFFSET));

        // Samples enter at the top of the shift register, so the first one
        // ends up in the least significant bit (or nibble) of the byte.
        if (sample) begin
            if (bw4_q) begin
                new_byte  = {DOUT, shift_q[7:4]};
                byte_done = (smp_cnt_q == 3'd1);
            end else begin
                new_byte  = {DOUT[0], shift_q[7:1]};
                byte_done = (smp_cnt_q == 3'd7);
            end
            shift_d   = new_byte;
            smp_cnt_d = byte_done ? 3'd0 : smp_cnt_q + 3'd1;
        end

        // A new byte always wins over the held one; it is only an overrun
        // if the held byte is not being taken in this very cycle.
        if (byte_done) begin
            data_d   = new_byte;
            dvalid_d = 1'b1;
            if (dvalid_q && !DREADY) begin
                overrun_d = 1'b1;
            end
        end else if (dvalid_q && DREADY) begin
            dvalid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d   = S_LEADIN;
                    tmr_d     = TMR_W'(BSS_CYCLES - 1);
                    boot_d    = BOOTMODE;
                    bw4_d     = BITWIDTH4;
                    overrun_d = 1'b0;
                    smp_cnt_d = 3'd0;
                    shift_d   = 8'h00;
                end
            end
            S_LEADIN: begin
                if (tmr_tc) begin
                    state_d = S_DELAY;
                    tmr_d   = TMR_W'(ACCESS_DELAY - 1);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_DELAY: begin
                if (tmr_tc) begin
                    state_d = S_READ;
                    tmr_d   = TMR_W'(READ_CYCLES - 1);
                    phase_d = '0;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_READ: begin
                phase_d = phase_wrap ? '0 : phase_q + PH_W'(1);
                if (tmr_tc) begin
                    state_d = S_TAIL;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_TAIL: begin
                state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes and status are decoded from the next state so that the
        // registered outputs line up with the state they describe.
        nbss_d    = !((state_d == S_LEADIN) || (state_d == S_DELAY) || (state_d == S_READ));
        nbsen_d   = (state_d != S_READ);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_FIN);
        nbooten_d = busy_d ? !boot_d : 1'b1;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge MCLK) begin
        if (MRST) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            phase_q   <= '0;
            smp_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            boot_q    <= 1'b0;
            bw4_q     <= 1'b0;
            data_q    <= 8'h00;
            dvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
            nbss_q    <= 1'b1;
            nbsen_q   <= 1'b1;
            nbooten_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            phase_q   <= phase_d;
            smp_cnt_q <= smp_cnt_d;
            shift_q   <= shift_d;
            boot_q    <= boot_d;
            bw4_q     <= bw4_d;
            data_q    <= data_d;
            dvalid_q  <= dvalid_d;
            overrun_q <= overrun_d;
            nbss_q    <= nbss_d;
            nbsen_q   <= nbsen_d;
            nbooten_q <= nbooten_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign nBSS    = nbss_q;
    assign nBSEN   = nbsen_q;
    assign nBOOTEN = nbooten_q;
    assign nREPEN  = 1'b1;
    assign nSWAPEN = 1'b1;
    assign DATA    = data_q;
    assign DVALID  = dvalid_q;
    assign OVERRUN = overrun_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_bubble_host_reader.sv
// Bench for bubble_host_reader: timeline model indexed by cycles since START.
module tb_bubble_host_reader;

    localparam int BC    = 12;
    localparam int OFF   = 6;
    localparam int L1    = 48;
    localparam int L2    = 96;
    localparam int PB    = 512;
    localparam int L12   = L1 + L2;
    localparam int L123  = L12 + PB * BC;
    localparam int TOTAL = L123 + 2;

    logic       MCLK = 1'b0;
    logic       MRST;
    logic       START;
    logic       BOOTMODE;
    logic       BITWIDTH4;
    logic [3:0] DOUT;
    logic       DREADY;
    logic       nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN;
    logic [7:0] DATA;
    logic       DVALID, BUSY, DONE, OVERRUN;

    bubble_host_reader dut (
        .MCLK      (MCLK),
        .MRST      (MRST),
        .START     (START),
        .BOOTMODE  (BOOTMODE),
        .BITWIDTH4 (BITWIDTH4),
        .DOUT      (DOUT),
        .nBSS      (nBSS),
        .nBSEN     (nBSEN),
        .nREPEN    (nREPEN),
        .nBOOTEN   (nBOOTEN),
        .nSWAPEN   (nSWAPEN),
        .DATA      (DATA),
        .DVALID    (DVALID),
        .DREADY    (DREADY),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .OVERRUN   (OVERRUN)
    );

    initial forever #5 MCLK = ~MCLK;

    // model: position in the page timeline plus handshake state
    bit         m_active, m_boot, m_bw4, m_dvalid, m_ovr, chk_en;
    int         m_pos;
    logic [7:0] m_data;
    logic [3:0] samp [0:PB-1];

    int         total, bad;
    int         dmode, drmode;
    int         nbss_low, nbsen_low, nboot_low, done_cnt;
    logic [7:0] rx_q [$];
    logic [8:0] a_ctrl, e_ctrl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] build(input int j, input bit bw4);
        logic [7:0] b;
        if (bw4) begin
            b = {samp[2*j+1], samp[2*j]};
        end else begin
            for (int i = 0; i < 8; i++) b[i] = samp[8*j+i][0];
        end
        return b;
    endfunction

    task automatic model_step();
        int r, k, per;
        bit cmpl;
        logic [7:0] nb;
        cmpl = 1'b0;
        nb = 8'h00;
        if (MRST) begin
            m_active = 0; m_pos = 0; m_boot = 0; m_bw4 = 0;
            m_dvalid = 0; m_data = 8'h00; m_ovr = 0; chk_en = 1;
            return;
        end
        if (m_active && m_pos >= L12 && m_pos < L123) begin
            r = m_pos - L12;
            if (r % BC == OFF) begin
                k = r / BC;
                samp[k] = DOUT;
                per = m_bw4 ? 2 : 8;
                if (k % per == per - 1) begin
                    cmpl = 1'b1;
                    nb = build(k / per, m_bw4);
                end
            end
        end
        if (cmpl) begin
            if (m_dvalid && !DREADY) m_ovr = 1;
            m_dvalid = 1;
            m_data = nb;
        end else if (m_dvalid && DREADY) begin
            m_dvalid = 0;
        end
        if (m_active) begin
            if (m_pos == TOTAL - 1) begin
                m_active = 0;
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end else if (START) begin
            m_active = 1; m_pos = 0;
            m_boot = BOOTMODE; m_bw4 = BITWIDTH4; m_ovr = 0;
        end
    endtask

    task automatic tick();
        int kk;
        @(posedge MCLK);
        #2;
        DOUT = 4'($urandom);
        if (m_active && m_pos >= L12 && m_pos < L123) begin
            kk = (m_pos - L12) / BC;
            if (dmode == 1) DOUT = {3'b000, ~kk[0]};
            else if (dmode == 2) DOUT = kk[0] ? 4'h5 : 4'hA;
        end
        case (drmode)
            0: DREADY = 1'b1;
            1: DREADY = 1'b0;
            default: DREADY = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic begin_page(input bit bw4, input bit boot);
        nbss_low = 0; nbsen_low = 0; nboot_low = 0; done_cnt = 0;
        rx_q.delete();
        BOOTMODE = boot;
        BITWIDTH4 = bw4;
        START = 1'b1;
        tick();
        START = 1'b0;
        BOOTMODE = ~boot;
        BITWIDTH4 = ~bw4;
    endtask

    task automatic wait_pos(input int p);
        int guard;
        guard = 0;
        while (!(m_active && m_pos == p) && guard < 8000) begin
            tick();
            guard++;
        end
        chk("wait_pos_timeout", guard < 8000, 1);
    endtask

    task automatic count_not(input logic [7:0] v, output int n);
        n = 0;
        foreach (rx_q[i]) if (rx_q[i] != v) n++;
    endtask

    initial begin
        int nbad;
        MRST = 1'b1; START = 1'b0; BOOTMODE = 1'b0; BITWIDTH4 = 1'b0;
        DOUT = 4'h0; DREADY = 1'b1;
        total = 0; bad = 0; dmode = 0; drmode = 0; chk_en = 0;
        fork
            forever begin
                @(posedge MCLK);
                model_step();
            end
            forever begin
                @(negedge MCLK);
                if (chk_en) begin
                    a_ctrl = {nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN, BUSY, DONE, DVALID, OVERRUN};
                    e_ctrl = {!(m_active && m_pos < L123),
                              !(m_active && m_pos >= L12 && m_pos < L123),
                              1'b1, (m_active ? ~m_boot : 1'b1), 1'b1,
                              m_active, (m_active && m_pos == TOTAL - 1),
                              m_dvalid, m_ovr};
                    chk("ctrl", a_ctrl, e_ctrl);
                    chk("data", DATA, m_data);
                    if (!nBSS) nbss_low++;
                    if (!nBSEN) nbsen_low++;
                    if (!nBOOTEN) nboot_low++;
                    if (DONE) done_cnt++;
                    if (DVALID && DREADY) rx_q.push_back(DATA);
                end
            end
            begin
                run(3);
                MRST = 1'b0;
                chk("rst_ctrl", {nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN, BUSY, DONE, DVALID, OVERRUN}, 9'h1F0);
                chk("rst_data", DATA, 8'h00);
                run(2);

                // 1-bit mode, toggling DOUT0, always ready
                dmode = 1; drmode = 0;
                begin_page(1'b0, 1'b0);
                run(TOTAL + 2);
                chk("p1_nbss_low", nbss_low, 6288);
                chk("p1_nbsen_low", nbsen_low, 6144);
                chk("p1_done", done_cnt, 1);
                chk("p1_bytes", rx_q.size(), 64);
                count_not(8'h55, nbad);
                chk("p1_not55", nbad, 0);
                chk("p1_ovr", OVERRUN, 0);

                // 4-bit mode, A/5 nibbles
                dmode = 2; drmode = 0;
                begin_page(1'b1, 1'b0);
                run(TOTAL + 2);
                chk("p2_bytes", rx_q.size(), 256);
                count_not(8'h5A, nbad);
                chk("p2_not5a", nbad, 0);
                chk("p2_ovr", OVERRUN, 0);
                chk("p2_done", done_cnt, 1);

                // boot mode, random data and handshake
                dmode = 0; drmode = 2;
                begin_page(1'($urandom_range(0, 1)), 1'b1);
                run(TOTAL + 2);
                chk("p3_nbooten_low", nboot_low, 6290);
                chk("p3_nbss_low", nbss_low, 6288);

                // consumer stalled for a whole 4-bit page
                dmode = 0; drmode = 1;
                begin_page(1'b1, 1'b0);
                run(TOTAL + 2);
                chk("p4_ovr", OVERRUN, 1);
                chk("p4_dvalid", DVALID, 1);
                chk("p4_last", DATA, build(255, 1'b1));
                drmode = 0;
                run(2);
                chk("p4_drained", DVALID, 0);

                // reset 100 cycles into READ
                dmode = 0; drmode = 1;
                begin_page(1'b1, 1'b1);
                wait_pos(L12 + 100);
                chk("p5_dvalid_pre", DVALID, 1);
                MRST = 1'b1;
                tick();
                MRST = 1'b0;
                chk("p5_strobes", {nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN}, 5'h1F);
                chk("p5_busy", BUSY, 0);
                chk("p5_dvalid", DVALID, 0);
                run(20);
                chk("p5_no_done", done_cnt, 0);
                MRST = 1'b1; START = 1'b1;
                tick();
                MRST = 1'b0; START = 1'b0;
                chk("p5_rst_over_start", BUSY, 0);
                drmode = 0;
                run(3);

                // START during DELAY and during FIN
                dmode = 0; drmode = 2;
                begin_page(1'b0, 1'b0);
                wait_pos(L1 + 10);
                START = 1'b1;
                tick();
                START = 1'b0;
                wait_pos(TOTAL - 1);
                START = 1'b1;
                tick();
                START = 1'b0;
                run(10);
                chk("p6_done", done_cnt, 1);
                chk("p6_idle", BUSY, 0);

                // random pages
                for (int p = 0; p < 3; p++) begin
                    dmode = 0; drmode = 2;
                    begin_page(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    run(TOTAL + $urandom_range(2, 20));
                    chk("rand_done", done_cnt, 1);
                end

                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        join
    end

endmodule
